// File: rtl/dmem_sync_ctrl_pkg.sv
// Shared codes and types for the dmem_sync_ctrl data memory: RV32 width codes,
// response error codes and controller state encodings.
package dmem_sync_ctrl_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    DMEM_ERR_OK       = 2'b00,
    DMEM_ERR_MISALIGN = 2'b01,
    DMEM_ERR_RANGE    = 2'b10,
    DMEM_ERR_ILLEGAL  = 2'b11
  } dmem_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: turns funct3 and the low address bits into a write
// mask, lane-replicated store data, legality flags and the extended load value.
module dmem_lsu_align
  import dmem_sync_ctrl_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    o_wmask    = '0;
    o_wdata    = '0;
    o_illegal  = 1'b0;
    o_misalign = 1'b0;
    o_rdata    = '0;
    case (i_funct3)
      FUNCT3_B, FUNCT3_BU: begin
        o_wmask   = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_illegal = i_we && (i_funct3 == FUNCT3_BU);
        o_rdata   = (i_funct3 == FUNCT3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      FUNCT3_H, FUNCT3_HU: begin
        o_wmask    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_illegal  = i_we && (i_funct3 == FUNCT3_HU);
        o_misalign = i_addr_lo[0];
        o_rdata    = (i_funct3 == FUNCT3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      FUNCT3_W: begin
        o_wmask    = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = |i_addr_lo;
        o_rdata    = i_rword;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_sync_ctrl.sv
// Synchronous byte-lane data RAM behind a valid/ready port, one request in flight.
// Define DMEM_STATS_EN to add saturating load/store/error counters.
module dmem_sync_ctrl
  import dmem_sync_ctrl_pkg::*;
#(
  parameter int          DEPTH_BYTES = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
`ifdef DMEM_STATS_EN
  ,parameter int         STAT_W      = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [1:0]  rsp_err_code_o
`ifdef DMEM_STATS_EN
  ,input  logic              stat_clr_i
  ,output logic [STAT_W-1:0] stat_loads_o
  ,output logic [STAT_W-1:0] stat_stores_o
  ,output logic [STAT_W-1:0] stat_errs_o
`endif
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = 4;

  logic [31:0]      r_mem [WORDS];
  dmem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  dmem_err_e        r_rsp_code;

  logic             w_accept;
  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [3:0]       w_wmask;
  logic [31:0]      w_wdata;
  logic             w_illegal;
  logic             w_misalign;
  logic [31:0]      w_rdata;
  dmem_err_e        w_code;

  assign req_ready_o = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready_i);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_offset    = req_addr_i - BASE_ADDR;
  assign w_in_range  = (req_addr_i >= BASE_ADDR) && (w_offset < 32'(DEPTH_BYTES));
  assign w_idx       = w_offset[IDX_W+1:2];
  assign w_rword     = r_mem[w_idx];

  dmem_lsu_align u_align (
    .i_we       (req_we_i),
    .i_funct3   (req_funct3_i),
    .i_addr_lo  (req_addr_i[1:0]),
    .i_wdata    (req_wdata_i),
    .i_rword    (w_rword),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_illegal  (w_illegal),
    .o_misalign (w_misalign),
    .o_rdata    (w_rdata)
  );

  always_comb begin
    w_code = DMEM_ERR_OK;
    if (w_illegal)        w_code = DMEM_ERR_ILLEGAL;
    else if (!w_in_range) w_code = DMEM_ERR_RANGE;
    else if (w_misalign)  w_code = DMEM_ERR_MISALIGN;
  end

  // Storage is never reset; a store commits on its accept edge regardless of what follows.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && req_we_i && (w_code == DMEM_ERR_OK)) begin
      for (int l = 0; l < 4; l++) begin
        if (w_wmask[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_code  <= DMEM_ERR_OK;
    end else if (w_accept) begin
      r_rsp_rdata <= (!req_we_i && (w_code == DMEM_ERR_OK)) ? w_rdata : 32'h0;
      r_rsp_err   <= (w_code != DMEM_ERR_OK);
      r_rsp_code  <= w_code;
      if (LATENCY == 1) begin
        r_state     <= ST_RESP;
        r_rsp_valid <= 1'b1;
      end else begin
        r_state     <= ST_WAIT;
        r_rsp_valid <= 1'b0;
        r_cnt       <= CNT_W'(LATENCY - 1);
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_rdata_o    = r_rsp_rdata;
  assign rsp_err_o      = r_rsp_err;
  assign rsp_err_code_o = r_rsp_code;

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] r_loads;
  logic [STAT_W-1:0] r_stores;
  logic [STAT_W-1:0] r_errs;
  logic              r_pend_we;
  logic              w_rsp_hs;

  assign w_rsp_hs = r_rsp_valid && rsp_ready_i;

  // r_pend_we remembers the direction of the in-flight access for classification at handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loads   <= '0;
      r_stores  <= '0;
      r_errs    <= '0;
      r_pend_we <= 1'b0;
    end else begin
      if (w_accept) r_pend_we <= req_we_i;
      if (stat_clr_i) begin
        r_loads  <= '0;
        r_stores <= '0;
        r_errs   <= '0;
      end else if (w_rsp_hs) begin
        if (r_rsp_err) begin
          if (r_errs != '1) r_errs <= r_errs + STAT_W'(1);
        end else if (r_pend_we) begin
          if (r_stores != '1) r_stores <= r_stores + STAT_W'(1);
        end else begin
          if (r_loads != '1) r_loads <= r_loads + STAT_W'(1);
        end
      end
    end
  end

  assign stat_loads_o  = r_loads;
  assign stat_stores_o = r_stores;
  assign stat_errs_o   = r_errs;
`endif

endmodule

// File: tb/tb_dmem_sync_ctrl.sv
// Bench for dmem_sync_ctrl: a LATENCY=1 instance (default size) and a LATENCY=3
// instance (1 KiB), directed vectors plus random traffic against a byte-array model.
module tb_dmem_sync_ctrl;
  import dmem_sync_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        aRst, aReqValid, aReqReady, aWe, aRspValid, aRspReady, aRspErr;
  logic [31:0] aAddr, aWdata, aRspRdata;
  logic [2:0]  aF3;
  logic [1:0]  aRspCode;
  logic        bRst, bReqValid, bReqReady, bWe, bRspValid, bRspReady, bRspErr;
  logic [31:0] bAddr, bWdata, bRspRdata;
  logic [2:0]  bF3;
  logic [1:0]  bRspCode;
`ifdef DMEM_STATS_EN
  logic        aStatClr, bStatClr;
  logic [31:0] aLoads, aStores, aErrs, bLoads, bStores, bErrs;
`endif

  dmem_sync_ctrl #(.DEPTH_BYTES(16384), .BASE_ADDR(32'h0), .LATENCY(1)) dutA (
    .clk(clk), .rst(aRst), .req_valid_i(aReqValid), .req_ready_o(aReqReady),
    .req_we_i(aWe), .req_addr_i(aAddr), .req_wdata_i(aWdata), .req_funct3_i(aF3),
    .rsp_valid_o(aRspValid), .rsp_ready_i(aRspReady), .rsp_rdata_o(aRspRdata),
    .rsp_err_o(aRspErr), .rsp_err_code_o(aRspCode)
`ifdef DMEM_STATS_EN
    ,.stat_clr_i(aStatClr), .stat_loads_o(aLoads), .stat_stores_o(aStores), .stat_errs_o(aErrs)
`endif
  );

  dmem_sync_ctrl #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0), .LATENCY(3)) dutB (
    .clk(clk), .rst(bRst), .req_valid_i(bReqValid), .req_ready_o(bReqReady),
    .req_we_i(bWe), .req_addr_i(bAddr), .req_wdata_i(bWdata), .req_funct3_i(bF3),
    .rsp_valid_o(bRspValid), .rsp_ready_i(bRspReady), .rsp_rdata_o(bRspRdata),
    .rsp_err_o(bRspErr), .rsp_err_code_o(bRspCode)
`ifdef DMEM_STATS_EN
    ,.stat_clr_i(bStatClr), .stat_loads_o(bLoads), .stat_stores_o(bStores), .stat_errs_o(bErrs)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] expData;
    logic [1:0]  expCode;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] mdl [16384];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses as size/offset arithmetic.
  function automatic void modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] f3, output logic [31:0] data, output logic [1:0] code);
    int size;
    logic [31:0] v;
    data = 32'h0;
    size = 1 << f3[1:0];
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) code = 2'd3;
    else if (addr >= 32'h4000) code = 2'd2;
    else if ((addr % size) != 0) code = 2'd1;
    else begin
      code = 2'd0;
      if (we) begin
        for (int i = 0; i < size; i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mdl[int'(addr) + i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        data = v;
      end
    end
  endfunction

  // One complete access on dutA; returns once the response handshake edge has passed.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, output logic [31:0] rdata, output logic [1:0] code,
                               output logic err);
    int guard;
    @(negedge clk);
    aReqValid = 1'b1; aWe = we; aAddr = addr; aWdata = wdata; aF3 = f3; aRspReady = 1'b1;
    guard = 0;
    #1;
    while (!aReqReady && guard < 20) begin @(negedge clk); #1; guard++; end
    if (!aReqReady) checkOutput("a accept timeout", 32'(aReqReady), 32'd1);
    @(posedge clk);
    #1 aReqValid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!aRspValid && guard < 20) begin @(negedge clk); guard++; end
    if (!aRspValid) checkOutput("a response timeout", 32'(aRspValid), 32'd1);
    rdata = aRspRdata; code = aRspCode; err = aRspErr;
    @(posedge clk);
    #1;
  endtask

  task automatic bSend(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    int guard;
    @(negedge clk);
    bReqValid = 1'b1; bWe = we; bAddr = addr; bWdata = wdata; bF3 = f3;
    guard = 0;
    #1;
    while (!bReqReady && guard < 20) begin @(negedge clk); #1; guard++; end
    if (!bReqReady) checkOutput("b accept timeout", 32'(bReqReady), 32'd1);
    @(posedge clk);
    #1 bReqValid = 1'b0;
  endtask

  task automatic bWaitRsp(output logic [31:0] data, output logic [1:0] code, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bRspValid && cyc < 20);
    if (!bRspValid) checkOutput("b response timeout", 32'(bRspValid), 32'd1);
    data = bRspRdata; code = bRspCode;
  endtask

  initial begin
    logic [31:0] d, e;
    logic [1:0]  c, ec;
    logic        er;
    int          cyc, seen;
    logic [31:0] expB2b [8];

    aRst = 1'b1; aReqValid = 1'b0; aWe = 1'b0; aAddr = '0; aWdata = '0; aF3 = '0; aRspReady = 1'b0;
    bRst = 1'b1; bReqValid = 1'b0; bWe = 1'b0; bAddr = '0; bWdata = '0; bF3 = '0; bRspReady = 1'b0;
`ifdef DMEM_STATS_EN
    aStatClr = 1'b0; bStatClr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    aRst = 1'b0; bRst = 1'b0;
    #1;
    checkOutput("reset rsp_valid", 32'(aRspValid), 32'd0);
    checkOutput("reset rdata", aRspRdata, 32'h0);
    checkOutput("reset err", 32'(aRspErr), 32'd0);
    checkOutput("reset code", 32'(aRspCode), 32'd0);
    checkOutput("reset req_ready", 32'(aReqReady), 32'd1);
    checkOutput("reset b rsp_valid", 32'(bRspValid), 32'd0);

    // Directed vectors: load extension, lane writes and error priority.
    vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 2'd0});
    vecs.push_back('{1'b0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 2'd0});
    vecs.push_back('{1'b0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 2'd0});
    vecs.push_back('{1'b0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 2'd0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 2'd0});
    vecs.push_back('{1'b1, 32'h11, 32'h55, 3'd0, 32'h0, 2'd0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 2'd0});
    vecs.push_back('{1'b1, 32'h11, 32'hAAAA, 3'd1, 32'h0, 2'd1});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 2'd0});
    vecs.push_back('{1'b0, 32'h11, 32'h0, 3'd4, 32'h00000055, 2'd0});
    vecs.push_back('{1'b0, 32'h12, 32'h0, 3'd5, 32'h0000DEAD, 2'd0});
    vecs.push_back('{1'b0, 32'h11, 32'h0, 3'd5, 32'h0, 2'd1});
    vecs.push_back('{1'b0, 32'h12, 32'h0, 3'd2, 32'h0, 2'd1});
    vecs.push_back('{1'b0, 32'h4000, 32'h0, 3'd2, 32'h0, 2'd2});
    vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'h0, 3'd2, 32'h0, 2'd2});
    vecs.push_back('{1'b0, 32'h4001, 32'h0, 3'd1, 32'h0, 2'd2});
    vecs.push_back('{1'b1, 32'h14, 32'h0, 3'd3, 32'h0, 2'd3});
    vecs.push_back('{1'b1, 32'h4000, 32'h0, 3'd3, 32'h0, 2'd3});
    vecs.push_back('{1'b1, 32'h17, 32'h0, 3'd4, 32'h0, 2'd3});
    vecs.push_back('{1'b0, 32'h4001, 32'h0, 3'd6, 32'h0, 2'd3});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, d, c, er);
      checkOutput($sformatf("vec%0d rdata", i), d, vecs[i].expData);
      checkOutput($sformatf("vec%0d code", i), 32'(c), 32'(vecs[i].expCode));
      checkOutput($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].expCode != 2'd0));
    end

    // Random traffic in 0x100..0x1FF (prefilled) with occasional out-of-range addresses.
    for (int i = 0; i < 64; i++) begin
      e = $urandom;
      modelAccess(1'b1, 32'h100 + 32'(4*i), e, 3'd2, d, ec);
      applyStimulus(1'b1, 32'h100 + 32'(4*i), e, 3'd2, d, c, er);
      checkOutput("prefill code", 32'(c), 32'(ec));
    end
    for (int i = 0; i < 200; i++) begin
      logic        rwe;
      logic [31:0] raddr, rwd;
      logic [2:0]  rf3;
      rwe   = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 1000)) : 32'h100 + 32'($urandom_range(0, 255));
      rwd   = $urandom;
      rf3   = 3'($urandom_range(0, 7));
      modelAccess(rwe, raddr, rwd, rf3, e, ec);
      applyStimulus(rwe, raddr, rwd, rf3, d, c, er);
      checkOutput($sformatf("rand%0d rdata", i), d, e);
      checkOutput($sformatf("rand%0d code", i), 32'(c), 32'(ec));
    end

    // Eight back-to-back word loads at LATENCY=1 with rsp_ready held high.
    for (int i = 0; i < 8; i++) modelAccess(1'b0, 32'h100 + 32'(4*i), 32'h0, 3'd2, expB2b[i], ec);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= 8) begin
        checkOutput("b2b valid", 32'(aRspValid), 32'd1);
        checkOutput($sformatf("b2b data%0d", n - 1), aRspRdata, expB2b[n-1]);
      end
      if (n == 9) checkOutput("b2b idle", 32'(aRspValid), 32'd0);
      if (n < 8) begin
        aReqValid = 1'b1; aWe = 1'b0; aAddr = 32'h100 + 32'(4*n); aF3 = 3'd2; aRspReady = 1'b1;
        #1 checkOutput("b2b ready", 32'(aReqReady), 32'd1);
      end else begin
        aReqValid = 1'b0;
      end
    end

    // LATENCY=3: response timing, then a 4-cycle stall with a competing request.
    bRspReady = 1'b1;
    bSend(1'b1, 32'h40, 32'hCAFEF00D, 3'd2);
    bWaitRsp(d, c, cyc);
    checkOutput("lat3 store cycles", 32'(cyc), 32'd3);
    checkOutput("lat3 store code", 32'(c), 32'd0);
    @(posedge clk);
    #1 bRspReady = 1'b0;
    bSend(1'b0, 32'h40, 32'h0, 3'd2);
    bWaitRsp(d, c, cyc);
    checkOutput("lat3 load cycles", 32'(cyc), 32'd3);
    checkOutput("lat3 load data", d, 32'hCAFEF00D);
    bReqValid = 1'b1; bWe = 1'b0; bAddr = 32'h44; bF3 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("stall req_ready", 32'(bReqReady), 32'd0);
      checkOutput("stall rsp_valid", 32'(bRspValid), 32'd1);
      checkOutput("stall rdata", bRspRdata, 32'hCAFEF00D);
      checkOutput("stall code", 32'(bRspCode), 32'd0);
    end
    @(negedge clk);
    bReqValid = 1'b0; bRspReady = 1'b1;
    @(negedge clk);
    checkOutput("stall release", 32'(bRspValid), 32'd0);
    bSend(1'b0, 32'h400, 32'h0, 3'd2);
    bWaitRsp(d, c, cyc);
    checkOutput("b range code", 32'(c), 32'd2);
    @(posedge clk);
    #1;

    // Reset while the store is waiting: response dropped, write kept.
    bSend(1'b1, 32'h20, 32'h1234, 3'd2);
    @(negedge clk);
    bRst = 1'b1;
    @(negedge clk);
    bRst = 1'b0;
    checkOutput("rst rdata", bRspRdata, 32'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bRspValid) seen++;
    end
    checkOutput("rst dropped response", 32'(seen), 32'd0);
    bSend(1'b0, 32'h20, 32'h0, 3'd2);
    bWaitRsp(d, c, cyc);
    checkOutput("rst store kept", d, 32'h1234);
    @(posedge clk);
    #1;

`ifdef DMEM_STATS_EN
    @(negedge clk); aStatClr = 1'b1;
    @(negedge clk); aStatClr = 1'b0;
    checkOutput("stat clr loads", aLoads, 32'd0);
    checkOutput("stat clr errs", aErrs, 32'd0);
    applyStimulus(1'b0, 32'h100, 32'h0, 3'd2, d, c, er);
    applyStimulus(1'b1, 32'h30, 32'h1, 3'd2, d, c, er);
    applyStimulus(1'b0, 32'h104, 32'h0, 3'd0, d, c, er);
    applyStimulus(1'b0, 32'h4000, 32'h0, 3'd2, d, c, er);
    applyStimulus(1'b1, 32'h34, 32'h2, 3'd1, d, c, er);
    applyStimulus(1'b0, 32'h108, 32'h0, 3'd5, d, c, er);
    checkOutput("stat loads", aLoads, 32'd3);
    checkOutput("stat stores", aStores, 32'd2);
    checkOutput("stat errs", aErrs, 32'd1);
    @(negedge clk);
    aReqValid = 1'b1; aWe = 1'b0; aAddr = 32'h100; aF3 = 3'd2; aRspReady = 1'b1;
    @(posedge clk);
    #1 aReqValid = 1'b0;
    @(negedge clk);
    checkOutput("clr-hs rsp_valid", 32'(aRspValid), 32'd1);
    aStatClr = 1'b1;
    @(posedge clk);
    #1 aStatClr = 1'b0;
    checkOutput("clr-hs loads", aLoads, 32'd0);
    checkOutput("clr-hs stores", aStores, 32'd0);
    checkOutput("clr-hs errs", aErrs, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: simulation did not finish, limit 2000000");
    $fatal(1, "[TB] timeout");
  end

endmodule
